mem_port_arbiter: RTL

- Next-generation memory controller between the CPU core and the 8-bit unified RAM/IO bus.
- Arbitrates the instruction-fetch unit (IF) against the load/store buffer (LSB); LSB has priority.
- Serialises multi-byte accesses onto the byte bus. IF reads a parametrised line width; LSB loads are sign- or zero-extended.
- Honours io_buffer_full, never issues reads beyond the requested length, and never aborts IO or store traffic on a flush.

---
 rtl/mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: serialises instruction-fetch lines and load/store
// accesses onto an 8-bit RAM/IO bus. The load/store buffer has priority.
// Optional feature macro: MC_FAIRNESS_EN (bounds how long IF can be starved).
module mem_port_arbiter #(
    parameter int unsigned LINE_BYTES   = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter logic [1:0]  IO_HI        = 2'b11,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clr_in,
    input  logic                    io_buffer_full,
    input  logic [7:0]              mem_to_mc_din,
    output logic [7:0]              mc_to_mem_dout,
    output logic [ADDR_W-1:0]       mc_to_mem_addr,
    output logic                    mc_to_mem_wr,
    input  logic                    if_to_mc_req,
    input  logic [ADDR_W-1:0]       if_to_mc_addr,
    output logic [LINE_BYTES*8-1:0] mc_to_if_line,
    output logic                    mc_to_if_done,
    input  logic                    lsb_to_mc_req,
    input  logic                    lsb_to_mc_we,
    input  logic [2:0]              lsb_to_mc_len,
    input  logic                    lsb_to_mc_signed,
    input  logic [ADDR_W-1:0]       lsb_to_mc_addr,
    input  logic [31:0]             lsb_to_mc_wdata,
    output logic [31:0]             mc_to_lsb_rdata,
    output logic                    mc_to_lsb_ld_done,
    output logic                    mc_to_lsb_st_done,
    output logic                    mc_to_lsb_idle
);

    localparam int unsigned LINE_W    = LINE_BYTES * 8;
    localparam int unsigned BUF_BYTES = (LINE_BYTES > 4) ? LINE_BYTES : 4;
    localparam int unsigned BUF_W     = BUF_BYTES * 8;
    localparam int unsigned IDX_W     = $clog2(BUF_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE, S_FETCH, S_WAIT_IO
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
    logic [4:0]          len_q, len_d, iss_q, iss_d, rd_q, rd_d;
    logic                pend_q, pend_d, io_q, io_d, sgn_q, sgn_d, wr_q, wr_d;
    logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]          dout_q, dout_d;
    logic [BUF_W-1:0]    rbuf_q, rbuf_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                if_done_q, if_done_d, ld_done_q, ld_done_d, st_done_q, st_done_d;
    logic                lsb_ok, if_ok, pick_lsb, pick_if, lsb_io;
    logic [IDX_W-1:0]    rd_pos;
`ifdef MC_FAIRNESS_EN
    logic [2:0]          starve_q, starve_d;
`endif

    // Zero- or sign-extend a 1/2/4-byte load result from bit 8*len-1.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [4:0] len,
                                           input logic sgn);
        case (len)
            5'd1:    extend = {{24{sgn & raw[7]}}, raw[7:0]};
            5'd2:    extend = {{16{sgn & raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    // Arbitration: a requester whose done pulse is still high is not regranted.
    always_comb begin
        lsb_ok = lsb_to_mc_req && !(ld_done_q || st_done_q);
        if_ok  = if_to_mc_req && !if_done_q;
`ifdef MC_FAIRNESS_EN
        pick_if = if_ok && (!lsb_ok || (32'(starve_q) >= STARVE_LIMIT));
`else
        pick_if = if_ok && !lsb_ok;
`endif
        pick_lsb = lsb_ok && !pick_if;
        lsb_io   = (lsb_to_mc_addr[17:16] == IO_HI);
        rd_pos   = IDX_W'({rd_q, 3'b000});
    end

    // Next-state and datapath: one byte per cycle, pipelined reads, IO pacing.
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;   base_d  = base_q;  addr_d  = addr_q;
        len_d     = len_q;     iss_d   = iss_q;   rd_d    = rd_q;
        pend_d    = pend_q;    io_d    = io_q;    sgn_d   = sgn_q;
        wr_d      = wr_q;      wdata_d = wdata_q; rdata_d = rdata_q;
        dout_d    = dout_q;    rbuf_d  = rbuf_q;  line_d  = line_q;
        if_done_d = if_done_q; ld_done_d = ld_done_q; st_done_d = st_done_q;
`ifdef MC_FAIRNESS_EN
        starve_d  = starve_q;
`endif
        if (rdy_in) begin
            if_done_d = 1'b0;
            ld_done_d = 1'b0;
            st_done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    wr_d   = 1'b0;
                    addr_d = '0;
                    if (pick_lsb) begin
                        base_d  = lsb_to_mc_addr;
                        addr_d  = lsb_to_mc_addr;
                        len_d   = {2'b00, lsb_to_mc_len};
                        sgn_d   = lsb_to_mc_signed;
                        wdata_d = lsb_to_mc_wdata;
                        io_d    = lsb_io;
                        rd_d    = '0;
`ifdef MC_FAIRNESS_EN
                        if (if_to_mc_req && starve_q != 3'd7) starve_d = starve_q + 3'd1;
`endif
                        if (!lsb_to_mc_we) begin
                            iss_d   = 5'd1;
                            pend_d  = 1'b1;
                            state_d = S_LOAD;
                        end else if (lsb_io && io_buffer_full) begin
                            iss_d   = '0;
                            state_d = S_WAIT_IO;
                        end else begin
                            wr_d    = 1'b1;
                            dout_d  = lsb_to_mc_wdata[7:0];
                            iss_d   = 5'd1;
                            state_d = S_STORE;
                        end
                    end else if (pick_if) begin
                        base_d  = if_to_mc_addr;
                        addr_d  = if_to_mc_addr;
                        len_d   = 5'(LINE_BYTES);
                        io_d    = 1'b0;
                        iss_d   = 5'd1;
                        rd_d    = '0;
                        pend_d  = 1'b1;
                        state_d = S_FETCH;
`ifdef MC_FAIRNESS_EN
                        starve_d = '0;
`endif
                    end
                end
                S_LOAD, S_FETCH: begin
                    if (clr_in && !(state_q == S_LOAD && io_q)) begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                        pend_d  = 1'b0;
                    end else if (!pend_q && rd_q == len_q) begin
                        state_d = S_IDLE;
                        if (state_q == S_FETCH) begin
                            if_done_d = 1'b1;
                            line_d    = rbuf_q[LINE_W-1:0];
                        end else begin
                            ld_done_d = 1'b1;
                            rdata_d   = extend(rbuf_q[31:0], len_q, sgn_q);
                        end
                    end else begin
                        if (pend_q) begin
                            rbuf_d[rd_pos +: 8] = mem_to_mc_din;
                            rd_d = rd_q + 5'd1;
                        end
                        // IO reads wait for the outstanding byte before the next address.
                        if (iss_q != len_q && !(io_q && pend_q)) begin
                            addr_d = base_q + ADDR_W'(iss_q);
                            iss_d  = iss_q + 5'd1;
                            pend_d = 1'b1;
                        end else begin
                            addr_d = '0;
                            pend_d = 1'b0;
                        end
                    end
                end
                S_STORE: begin
                    if (iss_q == len_q) begin
                        wr_d      = 1'b0;
                        addr_d    = '0;
                        st_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (io_q && io_buffer_full) begin
                        wr_d    = 1'b0;
                        addr_d  = base_q + ADDR_W'(iss_q);
                        state_d = S_WAIT_IO;
                    end else begin
                        wr_d   = 1'b1;
                        addr_d = base_q + ADDR_W'(iss_q);
                        dout_d = wdata_q[{iss_q[1:0], 3'b000} +: 8];
                        iss_d  = iss_q + 5'd1;
                    end
                end
                S_WAIT_IO: begin
                    wr_d = 1'b0;
                    if (!io_buffer_full) begin
                        wr_d    = 1'b1;
                        addr_d  = base_q + ADDR_W'(iss_q);
                        dout_d  = wdata_q[{iss_q[1:0], 3'b000} +: 8];
                        iss_d   = iss_q + 5'd1;
                        state_d = S_STORE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register with synchronous reset; a reset mid-store leaves written bytes alone.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;  base_q  <= '0; addr_q  <= '0; len_q <= '0;
            iss_q   <= '0;      rd_q    <= '0; pend_q  <= 1'b0; io_q <= 1'b0;
            sgn_q   <= 1'b0;    wr_q    <= 1'b0; wdata_q <= '0; rdata_q <= '0;
            dout_q  <= '0;      line_q  <= '0;
            if_done_q <= 1'b0;  ld_done_q <= 1'b0; st_done_q <= 1'b0;
            // NOTE: the byte buffer is small, so it is reset like the rest rather than left X.
            rbuf_q  <= '0;
`ifdef MC_FAIRNESS_EN
            starve_q <= '0;
`endif
        end else begin
            state_q <= state_d; base_q  <= base_d; addr_q  <= addr_d; len_q <= len_d;
            iss_q   <= iss_d;   rd_q    <= rd_d;   pend_q  <= pend_d; io_q  <= io_d;
            sgn_q   <= sgn_d;   wr_q    <= wr_d;   wdata_q <= wdata_d; rdata_q <= rdata_d;
            dout_q  <= dout_d;  line_q  <= line_d;
            if_done_q <= if_done_d; ld_done_q <= ld_done_d; st_done_q <= st_done_d;
            rbuf_q  <= rbuf_d;
`ifdef MC_FAIRNESS_EN
            starve_q <= starve_d;
`endif
        end
    end

    assign mc_to_mem_dout    = dout_q;
    assign mc_to_mem_addr    = addr_q;
    assign mc_to_mem_wr      = wr_q;
    assign mc_to_if_line     = line_q;
    assign mc_to_if_done     = if_done_q;
    assign mc_to_lsb_rdata   = rdata_q;
    assign mc_to_lsb_ld_done = ld_done_q;
    assign mc_to_lsb_st_done = st_done_q;
    assign mc_to_lsb_idle    = (state_q == S_IDLE);

endmodule
